// File: rtl/seq_mag_comp.sv
`timescale 1ns/1ps
// Multi-cycle magnitude comparator: walks a and b MSB-first, DIGIT bits per cycle,
// and exits at the first differing digit. Signed compare uses the offset-binary MSB flip.
module seq_mag_comp #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("seq_mag_comp: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic [WIDTH-1:0] msb_flip;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;

  // Flipping the sign bit maps two's complement onto an order-preserving unsigned code.
  assign msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};
  assign dig_a    = sa_q[WIDTH-1 -: DIGIT];
  assign dig_b    = sb_q[WIDTH-1 -: DIGIT];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a ^ msb_flip;
          sb_d    = b ^ msb_flip;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dig_a != dig_b) begin
          eq_d    = 1'b0;
          gt_d    = (dig_a > dig_b);
          lt_d    = (dig_a < dig_b);
          state_d = DONE;
        end else if (cnt_q == LAST_DIG) begin
          eq_d    = 1'b1;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          sa_d  = sa_q << DIGIT;
          sb_d  = sb_q << DIGIT;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together
  // at the edge; the datapath registers are reset too so no stale operand survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  // Handshake outputs come straight from the state register: no in->out combinational path.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
`timescale 1ns/1ps
// Bench for seq_mag_comp: directed vectors on an 8/2 instance plus randomized/exhaustive
// sweeps on four other geometries, each checked against an integer compare model.
module tb_seq_mag_comp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- main 8/2 instance ----------------
  logic       reset, in_valid, in_ready, signed_mode, out_valid, out_ready, eq, gt, lt;
  logic [7:0] a, b;

  seq_mag_comp #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .eq(eq), .gt(gt), .lt(lt)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic [2:0] flags;  // {eq, gt, lt}
    int         lat;    // cycle in which out_valid first rises (k+1)
  } vec_t;

  // Caller is at a negedge in IDLE. hold = DONE cycles with out_ready low; junk = drive
  // fresh operands with in_valid during those cycles.
  task automatic txn(input string name, input vec_t v, input int hold, input bit junk);
    int cyc;
    check({name, " in_ready"}, in_ready, 1);
    a = v.a; b = v.b; signed_mode = v.sm; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " latency"}, cyc, v.lat);
    check({name, " flags"}, {eq, gt, lt}, v.flags);
    for (int h = 0; h < hold; h++) begin
      if (junk) begin
        in_valid = 1'b1; a = ~v.a; b = ~v.b; signed_mode = ~v.sm;
      end
      @(negedge clk);
      check({name, " hold out_valid"}, out_valid, 1);
      check({name, " hold in_ready"}, in_ready, 0);
      check({name, " hold flags"}, {eq, gt, lt}, v.flags);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " back in IDLE"}, in_ready, 1);
    check({name, " out_valid drop"}, out_valid, 0);
    check({name, " flags kept"}, {eq, gt, lt}, v.flags);
  endtask

  // ---------------- sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int W  = (g == 0) ? 4 : 8;
    localparam int D  = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    localparam int ND = W / D;
    localparam int NT = (g == 0) ? 512 : 500;

    logic         s_reset, s_iv, s_ir, s_sm, s_ov, s_or, s_eq, s_gt, s_lt;
    logic [W-1:0] s_a, s_b;
    logic         done = 1'b0;

    seq_mag_comp #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk(clk), .reset(s_reset), .in_valid(s_iv), .in_ready(s_ir),
      .a(s_a), .b(s_b), .signed_mode(s_sm), .out_valid(s_ov),
      .out_ready(s_or), .eq(s_eq), .gt(s_gt), .lt(s_lt)
    );

    initial begin
      string        tag;
      logic [W-1:0] ta, tb, x;
      logic         tsm;
      int           va, vb, p, k, cyc;
      logic [2:0]   ef;
      tag = $sformatf("sweep W%0d D%0d", W, D);
      s_reset = 1'b1; s_iv = 1'b0; s_or = 1'b0; s_a = '0; s_b = '0; s_sm = 1'b0;
      repeat (2) @(negedge clk);
      s_reset = 1'b0;
      for (int n = 0; n < NT; n++) begin
        if (W == 4) begin
          ta = W'(n); tb = W'(n >> 4); tsm = 1'(n >> 8);
        end else begin
          ta  = W'($urandom);
          // Half the pairs differ in one random bit so late digits get exercised.
          tb  = ($urandom_range(0, 1) == 1) ? W'($urandom) : ta ^ W'((1 << $urandom_range(0, W)) >> 1);
          tsm = 1'($urandom);
        end
        // Reference: plain integer compare, and first differing digit from the XOR.
        va = int'(ta); vb = int'(tb);
        if (tsm && ta[W-1]) va -= (1 << W);
        if (tsm && tb[W-1]) vb -= (1 << W);
        ef = (va == vb) ? 3'b100 : (va > vb) ? 3'b010 : 3'b001;
        x = ta ^ tb;
        p = -1;
        for (int i = 0; i < W; i++) if (x[i]) p = i;
        k = (p < 0) ? ND : (W - 1 - p) / D + 1;

        repeat ($urandom_range(0, 2)) begin
          s_iv = 1'b0; s_or = 1'($urandom);
          @(negedge clk);
        end
        check({tag, " in_ready"}, s_ir, 1);
        s_a = ta; s_b = tb; s_sm = tsm; s_iv = 1'b1; s_or = 1'($urandom);
        @(negedge clk);
        cyc = 1;
        while (!s_ov && cyc < 20) begin
          s_iv = 1'($urandom); s_a = W'($urandom); s_b = W'($urandom);
          s_sm = 1'($urandom); s_or = 1'($urandom);
          @(negedge clk);
          cyc++;
        end
        check({tag, " latency"}, cyc, k + 1);
        check({tag, " flags"}, {s_eq, s_gt, s_lt}, ef);
        check({tag, " one-hot"}, int'(s_eq) + int'(s_gt) + int'(s_lt), 1);
        check({tag, " in_ready in DONE"}, s_ir, 0);
        repeat ($urandom_range(0, 2)) begin
          s_iv = 1'($urandom); s_or = 1'b0;
          @(negedge clk);
          check({tag, " hold flags"}, {s_eq, s_gt, s_lt, s_ov}, {ef, 1'b1});
        end
        s_iv = 1'($urandom); s_or = 1'b1;
        @(negedge clk);
        s_iv = 1'b0; s_or = 1'b0;
        check({tag, " release"}, {s_ov, s_ir}, 2'b01);
      end
      done = 1'b1;
    end
  end

  // ---------------- directed sequence on the main instance ----------------
  initial begin
    vec_t vecs[10];
    vec_t bp;
    int   t;
    vecs[0] = '{8'hA5, 8'hA5, 1'b0, 3'b100, 5};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 3'b010, 2};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 3'b001, 2};
    vecs[3] = '{8'hA4, 8'hA5, 1'b0, 3'b001, 5};
    vecs[4] = '{8'hFF, 8'hFE, 1'b1, 3'b010, 5};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 3'b100, 5};
    vecs[6] = '{8'h34, 8'h38, 1'b0, 3'b001, 4};
    vecs[7] = '{8'hFF, 8'h01, 1'b1, 3'b001, 2};
    vecs[8] = '{8'h01, 8'h00, 1'b0, 3'b010, 5};
    vecs[9] = '{8'h80, 8'h80, 1'b1, 3'b100, 5};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset flags", {eq, gt, lt}, 3'b000);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) txn($sformatf("vec%0d", i), vecs[i], i % 3, 1'b0);

    // Backpressure with new operands offered while the result waits.
    bp = '{8'h80, 8'h7F, 1'b1, 3'b001, 2};
    txn("backpressure", bp, 3, 1'b1);
    @(negedge clk);
    check("bp junk ignored", {in_ready, out_valid}, 2'b10);

    // Reset asserted in cycle 2 of an A5/A5 compare.
    a = 8'hA5; b = 8'hA5; signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid-run reset in_ready", in_ready, 1);
    check("mid-run reset out_valid", out_valid, 0);
    check("mid-run reset flags", {eq, gt, lt}, 3'b000);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("no stale result", out_valid, 0);
    end

    t = 0;
    while (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done && g_sweep[3].done)
           && t < 50000) begin
      @(negedge clk);
      t++;
    end
    check("sweeps completed", {g_sweep[0].done, g_sweep[1].done, g_sweep[2].done,
                               g_sweep[3].done}, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
